lsu_io_access_ctrl: RTL and testbench

- Sequences non-cacheable (IO) loads/stores, i.e. those tagged is_io by the LSU PMA check, onto the uncached IO bus.
- One outstanding IO access at a time.
- Access waits until it is non-speculative (ROB commit indication), issues on a valid/ready bus, collects the response (with timeout), then reports completion to the LSQ.
- Sits between the LSQ and the IO bus port, beside the D-cache path.

---
 rtl/lsu_io_access_ctrl_pkg.sv | 32 +++
 rtl/lsu_io_data_align.sv | 63 ++++++
 rtl/lsu_io_access_ctrl.sv | 167 ++++++++++++++++
 tb/tb_lsu_io_access_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_io_access_ctrl_pkg.sv
// Shared types and constants for the LSU uncached IO access path.
package lsu_io_access_ctrl_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StWaitCommit,
      StReq,
      StResp,
      StDone
   } io_state_e;

   localparam logic [1:0] LSU_SIZE_B = 2'd0;
   localparam logic [1:0] LSU_SIZE_H = 2'd1;
   localparam logic [1:0] LSU_SIZE_W = 2'd2;
   localparam logic [1:0] LSU_SIZE_D = 2'd3;

   localparam int unsigned IO_TIMEOUT_DEFAULT = 1024;

   // Natural alignment: offset must be a multiple of the access size in bytes.
   function automatic logic lsu_is_misaligned(input logic [1:0] size, input logic [2:0] offset);
      logic r;
      r = 1'b0;
      case (size)
         LSU_SIZE_H: r = offset[0];
         LSU_SIZE_W: r = |offset[1:0];
         LSU_SIZE_D: r = |offset;
         default:    r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/lsu_io_data_align.sv
// Byte-lane alignment for an 8-byte data lane: store shift/strobes and load shift/extend.
module lsu_io_data_align
   import lsu_io_access_ctrl_pkg::*;
#(
   parameter int unsigned XLEN = 64
) (
   input  logic [1:0]        i_size,
   input  logic [2:0]        i_offset,
   input  logic              i_unsigned,
   input  logic [XLEN-1:0]   i_st_data,
   output logic [XLEN-1:0]   o_st_data,
   output logic [XLEN/8-1:0] o_st_mask,
   input  logic [XLEN-1:0]   i_ld_data,
   output logic [XLEN-1:0]   o_ld_data
);

   localparam int unsigned NB = XLEN / 8;

   logic [5:0]      w_shamt;
   logic [NB-1:0]   w_base_mask;
   logic [XLEN-1:0] w_ld_sh;
   logic            w_sx;

   assign w_shamt = {i_offset, 3'b000};

   always_comb begin
      w_base_mask = NB'(8'h01);
      case (i_size)
         LSU_SIZE_H: w_base_mask = NB'(8'h03);
         LSU_SIZE_W: w_base_mask = NB'(8'h0F);
         LSU_SIZE_D: w_base_mask = NB'(8'hFF);
         default:    w_base_mask = NB'(8'h01);
      endcase
   end

   assign o_st_mask = w_base_mask << i_offset;
   assign o_st_data = i_st_data << w_shamt;
   assign w_ld_sh   = i_ld_data >> w_shamt;

   always_comb begin
      w_sx      = 1'b0;
      o_ld_data = w_ld_sh;
      case (i_size)
         LSU_SIZE_B: begin
            w_sx      = ~i_unsigned & w_ld_sh[7];
            o_ld_data = {{(XLEN-8){w_sx}}, w_ld_sh[7:0]};
         end
         LSU_SIZE_H: begin
            w_sx      = ~i_unsigned & w_ld_sh[15];
            o_ld_data = {{(XLEN-16){w_sx}}, w_ld_sh[15:0]};
         end
         LSU_SIZE_W: begin
            w_sx      = ~i_unsigned & w_ld_sh[31];
            o_ld_data = {{(XLEN-32){w_sx}}, w_ld_sh[31:0]};
         end
         default: begin
            w_sx      = 1'b0;
            o_ld_data = w_ld_sh;
         end
      endcase
   end

endmodule

// File: rtl/lsu_io_access_ctrl.sv
// Sequences one non-speculative uncached IO load/store at a time onto the IO bus and
// reports completion back to the LSQ.
module lsu_io_access_ctrl
   import lsu_io_access_ctrl_pkg::*;
#(
   parameter int unsigned PHYSICAL_ADDR_LEN = 56,
   parameter int unsigned XLEN              = 64,
   parameter int unsigned LSQ_TAG_WIDTH     = 4,
   parameter int unsigned IO_TIMEOUT        = IO_TIMEOUT_DEFAULT
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         lsq_io_req_vld_i,
   output logic                         lsq_io_req_rdy_o,
   input  logic                         lsq_io_req_is_ld_i,
   input  logic [PHYSICAL_ADDR_LEN-1:0] lsq_io_req_paddr_i,
   input  logic [XLEN-1:0]              lsq_io_req_wdata_i,
   input  logic [1:0]                   lsq_io_req_size_i,
   input  logic                         lsq_io_req_unsigned_i,
   input  logic [LSQ_TAG_WIDTH-1:0]     lsq_io_req_tag_i,
   input  logic                         rob_io_commit_i,
   output logic                         io_bus_req_vld_o,
   input  logic                         io_bus_req_rdy_i,
   output logic                         io_bus_req_we_o,
   output logic [PHYSICAL_ADDR_LEN-1:0] io_bus_req_addr_o,
   output logic [XLEN-1:0]              io_bus_req_wdata_o,
   output logic [XLEN/8-1:0]            io_bus_req_wmask_o,
   input  logic                         io_bus_resp_vld_i,
   input  logic [XLEN-1:0]              io_bus_resp_data_i,
   input  logic                         io_bus_resp_err_i,
   output logic                         io_lsq_done_vld_o,
   output logic [LSQ_TAG_WIDTH-1:0]     io_lsq_done_tag_o,
   output logic [XLEN-1:0]              io_lsq_done_data_o,
   output logic                         io_lsq_done_err_o
);

   localparam int unsigned CNT_W = $clog2(IO_TIMEOUT);

   io_state_e                    r_state;
   logic                         r_rdy;
   logic                         r_bus_vld;
   logic                         r_is_ld;
   logic [PHYSICAL_ADDR_LEN-1:0] r_paddr;
   logic [XLEN-1:0]              r_wdata;
   logic [1:0]                   r_size;
   logic                         r_unsigned;
   logic [LSQ_TAG_WIDTH-1:0]     r_tag;
   logic [CNT_W-1:0]             r_cnt;
   logic                         r_done_vld;
   logic [XLEN-1:0]              r_done_data;
   logic                         r_done_err;

   logic [XLEN-1:0]              w_st_data;
   logic [XLEN/8-1:0]            w_st_mask;
   logic [XLEN-1:0]              w_ld_data;
   logic                         w_misaligned;

   lsu_io_data_align #(
      .XLEN (XLEN)
   ) u_align (
      .i_size     (r_size),
      .i_offset   (r_paddr[2:0]),
      .i_unsigned (r_unsigned),
      .i_st_data  (r_wdata),
      .o_st_data  (w_st_data),
      .o_st_mask  (w_st_mask),
      .i_ld_data  (io_bus_resp_data_i),
      .o_ld_data  (w_ld_data)
   );

   assign w_misaligned = lsu_is_misaligned(r_size, r_paddr[2:0]);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= StIdle;
         r_rdy       <= 1'b0;
         r_bus_vld   <= 1'b0;
         r_is_ld     <= 1'b0;
         r_paddr     <= '0;
         r_wdata     <= '0;
         r_size      <= LSU_SIZE_B;
         r_unsigned  <= 1'b0;
         r_tag       <= '0;
         r_cnt       <= '0;
         r_done_vld  <= 1'b0;
         r_done_data <= '0;
         r_done_err  <= 1'b0;
      end else begin
         r_done_vld <= 1'b0;
         case (r_state)
            StIdle: begin
               r_rdy <= 1'b1;
               // A flush in the accept cycle kills the request before it is captured.
               if (lsq_io_req_vld_i && r_rdy && !flush) begin
                  r_is_ld    <= lsq_io_req_is_ld_i;
                  r_paddr    <= lsq_io_req_paddr_i;
                  r_wdata    <= lsq_io_req_wdata_i;
                  r_size     <= lsq_io_req_size_i;
                  r_unsigned <= lsq_io_req_unsigned_i;
                  r_tag      <= lsq_io_req_tag_i;
                  r_rdy      <= 1'b0;
                  r_state    <= StWaitCommit;
               end
            end
            StWaitCommit: begin
               if (flush) begin
                  r_rdy   <= 1'b1;
                  r_state <= StIdle;
               end else if (rob_io_commit_i) begin
                  if (w_misaligned) begin
                     r_done_vld  <= 1'b1;
                     r_done_err  <= 1'b1;
                     r_done_data <= '0;
                     r_state     <= StDone;
                  end else begin
                     r_bus_vld <= 1'b1;
                     r_state   <= StReq;
                  end
               end
            end
            StReq: begin
               if (io_bus_req_rdy_i) begin
                  r_bus_vld <= 1'b0;
                  r_cnt     <= '0;
                  r_state   <= StResp;
               end
            end
            StResp: begin
               r_cnt <= r_cnt + 1'b1;
               // A response in the limit cycle still wins over the timeout.
               if (io_bus_resp_vld_i) begin
                  r_done_vld  <= 1'b1;
                  r_done_err  <= io_bus_resp_err_i;
                  r_done_data <= (io_bus_resp_err_i || !r_is_ld) ? '0 : w_ld_data;
                  r_state     <= StDone;
               end else if (r_cnt == CNT_W'(IO_TIMEOUT - 1)) begin
                  r_done_vld  <= 1'b1;
                  r_done_err  <= 1'b1;
                  r_done_data <= '0;
                  r_state     <= StDone;
               end
            end
            StDone: begin
               r_rdy   <= 1'b1;
               r_state <= StIdle;
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign lsq_io_req_rdy_o   = r_rdy;
   assign io_bus_req_vld_o   = r_bus_vld;
   assign io_bus_req_we_o    = r_bus_vld & ~r_is_ld;
   assign io_bus_req_addr_o  = r_bus_vld ? {r_paddr[PHYSICAL_ADDR_LEN-1:3], 3'b000} : '0;
   assign io_bus_req_wdata_o = r_bus_vld ? w_st_data : '0;
   assign io_bus_req_wmask_o = r_bus_vld ? w_st_mask : '0;

   assign io_lsq_done_vld_o  = r_done_vld;
   assign io_lsq_done_tag_o  = r_tag;
   assign io_lsq_done_data_o = r_done_data;
   assign io_lsq_done_err_o  = r_done_err;

endmodule

// File: tb/tb_lsu_io_access_ctrl.sv
// Randomized self-checking bench for lsu_io_access_ctrl against a transaction-level model.
module tb_lsu_io_access_ctrl;

   localparam int PAL = 56;
   localparam int XL  = 64;
   localparam int TW  = 4;
   localparam int TO  = 16;

   logic           clk = 1'b0;
   logic           rst;
   logic           flush;
   logic           req_vld;
   logic           req_rdy;
   logic           req_is_ld;
   logic [PAL-1:0] req_paddr;
   logic [XL-1:0]  req_wdata;
   logic [1:0]     req_size;
   logic           req_uns;
   logic [TW-1:0]  req_tag;
   logic           commit;
   logic           bus_vld;
   logic           bus_rdy;
   logic           bus_we;
   logic [PAL-1:0] bus_addr;
   logic [XL-1:0]  bus_wdata;
   logic [7:0]     bus_wmask;
   logic           resp_vld;
   logic [XL-1:0]  resp_data;
   logic           resp_err;
   logic           done_vld;
   logic [TW-1:0]  done_tag;
   logic [XL-1:0]  done_data;
   logic           done_err;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   lsu_io_access_ctrl #(
      .PHYSICAL_ADDR_LEN (PAL),
      .XLEN              (XL),
      .LSQ_TAG_WIDTH     (TW),
      .IO_TIMEOUT        (TO)
   ) dut (
      .clk                   (clk),
      .rst                   (rst),
      .flush                 (flush),
      .lsq_io_req_vld_i      (req_vld),
      .lsq_io_req_rdy_o      (req_rdy),
      .lsq_io_req_is_ld_i    (req_is_ld),
      .lsq_io_req_paddr_i    (req_paddr),
      .lsq_io_req_wdata_i    (req_wdata),
      .lsq_io_req_size_i     (req_size),
      .lsq_io_req_unsigned_i (req_uns),
      .lsq_io_req_tag_i      (req_tag),
      .rob_io_commit_i       (commit),
      .io_bus_req_vld_o      (bus_vld),
      .io_bus_req_rdy_i      (bus_rdy),
      .io_bus_req_we_o       (bus_we),
      .io_bus_req_addr_o     (bus_addr),
      .io_bus_req_wdata_o    (bus_wdata),
      .io_bus_req_wmask_o    (bus_wmask),
      .io_bus_resp_vld_i     (resp_vld),
      .io_bus_resp_data_i    (resp_data),
      .io_bus_resp_err_i     (resp_err),
      .io_lsq_done_vld_o     (done_vld),
      .io_lsq_done_tag_o     (done_tag),
      .io_lsq_done_data_o    (done_data),
      .io_lsq_done_err_o     (done_err)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Transaction-level model of the access rules.
   function automatic logic [7:0] m_mask(input int sz, input int off);
      int w;
      w = (1 << (1 << sz)) - 1;
      return 8'((w << off) & 255);
   endfunction

   function automatic logic [63:0] m_ld(input logic [63:0] d, input int sz, input int off,
                                        input bit uns);
      logic [63:0] v;
      logic [63:0] m;
      int          bits;
      v    = d >> (8 * off);
      bits = 8 * (1 << sz);
      if (bits < 64) begin
         m = (64'd1 << bits) - 64'd1;
         v = v & m;
         if (!uns && v[bits-1]) v = v | ~m;
      end
      return v;
   endfunction

   function automatic bit m_mis(input int sz, input int off);
      return (off % (1 << sz)) != 0;
   endfunction

   task automatic check_req(input bit ld, input int sz, input logic [55:0] pa,
                            input logic [63:0] wd);
      int off;
      off = int'(pa[2:0]);
      check_eq("bus_vld",   bus_vld, 1'b1);
      check_eq("bus_we",    bus_we, !ld);
      check_eq("bus_addr",  bus_addr, {pa[55:3], 3'b000});
      check_eq("bus_wdata", bus_wdata, wd << (8 * off));
      check_eq("bus_wmask", bus_wmask, m_mask(sz, off));
   endtask

   // scen: 0 normal, 1 flush at accept, 2 flush in wait, 3 flush+commit,
   //       4 flush held through REQ/RESP, 5 no response (timeout)
   task automatic run_txn(input bit ld, input int sz, input logic [55:0] pa,
                          input logic [63:0] wd, input bit uns, input logic [3:0] tag,
                          input int scen, input int cdly, input int rdly, input int qdly,
                          input logic [63:0] rd, input bit rerr);
      int off;
      bit mis;
      int t;
      off = int'(pa[2:0]);
      mis = m_mis(sz, off);
      t   = 0;
      while (!req_rdy && t < 10) begin
         @(negedge clk);
         t++;
      end
      check_eq("req_rdy", req_rdy, 1'b1);
      req_vld   = 1'b1;
      req_is_ld = ld;
      req_paddr = pa;
      req_wdata = wd;
      req_size  = 2'(sz);
      req_uns   = uns;
      req_tag   = tag;
      flush     = (scen == 1);
      @(negedge clk);
      req_vld = 1'b0;
      flush   = 1'b0;
      if (scen == 1) begin
         check_eq("flush_acc_rdy", req_rdy, 1'b1);
         check_eq("flush_acc_bus", bus_vld, 1'b0);
         check_eq("flush_acc_done", done_vld, 1'b0);
         return;
      end
      check_eq("acc_rdy_low", req_rdy, 1'b0);
      for (int i = 0; i < cdly; i++) begin
         @(negedge clk);
         check_eq("wait_bus", bus_vld, 1'b0);
         check_eq("wait_done", done_vld, 1'b0);
      end
      if (scen == 2 || scen == 3) begin
         flush  = 1'b1;
         commit = (scen == 3);
         @(negedge clk);
         flush  = 1'b0;
         commit = 1'b0;
         check_eq("flush_wait_rdy", req_rdy, 1'b1);
         check_eq("flush_wait_bus", bus_vld, 1'b0);
         check_eq("flush_wait_done", done_vld, 1'b0);
         return;
      end
      commit = 1'b1;
      @(negedge clk);
      commit = 1'b0;
      flush  = (scen == 4);
      if (mis) begin
         check_eq("mis_bus", bus_vld, 1'b0);
         check_eq("mis_done", done_vld, 1'b1);
         check_eq("mis_err", done_err, 1'b1);
         check_eq("mis_data", done_data, 64'd0);
         check_eq("mis_tag", done_tag, tag);
         @(negedge clk);
         flush = 1'b0;
         check_eq("mis_done_end", done_vld, 1'b0);
         check_eq("mis_rdy", req_rdy, 1'b1);
         return;
      end
      for (int i = 0; i < rdly; i++) begin
         check_req(ld, sz, pa, wd);
         @(negedge clk);
      end
      check_req(ld, sz, pa, wd);
      bus_rdy = 1'b1;
      @(negedge clk);
      bus_rdy = 1'b0;
      check_eq("resp_bus_low", bus_vld, 1'b0);
      if (scen == 5) begin
         for (int i = 0; i < TO; i++) begin
            check_eq("to_wait_done", done_vld, 1'b0);
            @(negedge clk);
         end
         check_eq("to_done", done_vld, 1'b1);
         check_eq("to_err", done_err, 1'b1);
         check_eq("to_data", done_data, 64'd0);
         check_eq("to_tag", done_tag, tag);
         resp_vld  = 1'b1;
         resp_data = rd;
         resp_err  = 1'b0;
         @(negedge clk);
         resp_vld = 1'b0;
         check_eq("stray_done", done_vld, 1'b0);
         check_eq("stray_rdy", req_rdy, 1'b1);
         @(negedge clk);
         check_eq("stray_done2", done_vld, 1'b0);
         return;
      end
      for (int i = 0; i < qdly; i++) begin
         check_eq("resp_wait_done", done_vld, 1'b0);
         @(negedge clk);
      end
      resp_vld  = 1'b1;
      resp_data = rd;
      resp_err  = rerr;
      @(negedge clk);
      resp_vld = 1'b0;
      resp_err = 1'b0;
      flush    = 1'b0;
      check_eq("done_vld", done_vld, 1'b1);
      check_eq("done_tag", done_tag, tag);
      check_eq("done_err", done_err, rerr);
      check_eq("done_data", done_data, (rerr || !ld) ? 64'd0 : m_ld(rd, sz, off, uns));
      @(negedge clk);
      check_eq("done_pulse_end", done_vld, 1'b0);
      check_eq("done_rdy", req_rdy, 1'b1);
   endtask

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      req_vld   = 1'b0;
      req_is_ld = 1'b0;
      req_paddr = '0;
      req_wdata = '0;
      req_size  = 2'd0;
      req_uns   = 1'b0;
      req_tag   = '0;
      commit    = 1'b0;
      bus_rdy   = 1'b0;
      resp_vld  = 1'b0;
      resp_data = '0;
      resp_err  = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_rdy", req_rdy, 1'b0);
      check_eq("rst_bus_vld", bus_vld, 1'b0);
      check_eq("rst_we", bus_we, 1'b0);
      check_eq("rst_mask", bus_wmask, 8'h00);
      check_eq("rst_done", done_vld, 1'b0);
      check_eq("rst_done_data", done_data, 64'd0);
      rst = 1'b0;
      @(negedge clk);
      check_eq("post_rst_rdy", req_rdy, 1'b1);

      // Directed cases.
      run_txn(1, 2, 56'h1000_0004, 64'h0, 0, 4'h3, 0, 0, 0, 0, 64'h8000_0001_1234_5678, 0);
      run_txn(0, 0, 56'h1000_0003, 64'hAB, 0, 4'h5, 0, 0, 5, 1, 64'h0, 0);
      run_txn(1, 3, 56'h1000_0008, 64'h0, 0, 4'h6, 2, 1, 0, 0, 64'h0, 0);
      run_txn(1, 3, 56'h1000_0008, 64'h0, 0, 4'h7, 3, 0, 0, 0, 64'h0, 0);
      run_txn(1, 1, 56'h1000_0006, 64'h0, 1, 4'h8, 0, 0, 0, 0, 64'hBEEF_0000_0000_0000, 0);
      run_txn(1, 0, 56'h1000_0005, 64'h0, 0, 4'h9, 4, 0, 2, 2, 64'h0000_9A00_0000_0000, 0);
      run_txn(1, 2, 56'h1000_0000, 64'h0, 0, 4'hA, 5, 0, 0, 0, 64'h1234, 0);
      run_txn(1, 1, 56'h1000_0001, 64'h0, 0, 4'hB, 0, 0, 0, 0, 64'h0, 0);
      run_txn(1, 3, 56'h1000_0010, 64'h0, 0, 4'hC, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
      run_txn(1, 2, 56'h1000_0000, 64'h0, 0, 4'hD, 0, 0, 0, TO - 1, 64'h7FFF_FFFF, 0);

      // Reset in the middle of a bus request.
      req_vld   = 1'b1;
      req_is_ld = 1'b1;
      req_size  = 2'd3;
      req_paddr = 56'h2000_0000;
      @(negedge clk);
      req_vld = 1'b0;
      commit  = 1'b1;
      @(negedge clk);
      commit = 1'b0;
      check_eq("mid_rst_req", bus_vld, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      check_eq("mid_rst_bus", bus_vld, 1'b0);
      check_eq("mid_rst_done", done_vld, 1'b0);
      check_eq("mid_rst_rdy", req_rdy, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      check_eq("mid_rst_idle", req_rdy, 1'b1);

      // Randomized traffic.
      for (int n = 0; n < 80; n++) begin
         bit          ld;
         int          sz;
         logic [55:0] pa;
         int          sc;
         int          q;
         ld = 1'($urandom_range(0, 1));
         sz = $urandom_range(0, 3);
         pa = {24'($urandom), $urandom};
         if ($urandom_range(0, 3) != 0) pa[2:0] = pa[2:0] & ~3'((1 << sz) - 1);
         case ($urandom_range(0, 9))
            0:       sc = 1;
            1:       sc = 2;
            2:       sc = 3;
            3:       sc = 4;
            4:       sc = 5;
            default: sc = 0;
         endcase
         q = ($urandom_range(0, 4) == 0) ? $urandom_range(0, TO - 1) : $urandom_range(0, 2);
         run_txn(ld, sz, pa, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                 4'($urandom), sc, $urandom_range(0, 2), $urandom_range(0, 3), q,
                 {$urandom, $urandom}, ($urandom_range(0, 7) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
